reverb_tap_mac: RTL

Convolution multiply-accumulate stage directly downstream of the memory controller. It consumes the alternating impulse-word / delayed-sample stream the controller reads from SRAM or off-chip memory during each ADC sample period. It accumulates signed, weighted taps into a wide accumulator and emits one saturated 16-bit reverb sample per frame to the output/DAC path.

---
 rtl/reverb_tap_mac_pkg.sv | 19 +
 rtl/reverb_tap_mac_tap_multiplier.sv | 30 +++
 rtl/reverb_tap_mac.sv | 107 ++++++++++
 3 files changed

// File: rtl/reverb_tap_mac_pkg.sv
// Shared constants for the reverb convolution path: impulse-word layout, MAC
// state encoding and output scaling. The memory controller imports the field positions.
package reverb_tap_mac_pkg;
  localparam int NEG_BIT     = 8;
  localparam int MULT_MSB    = 7;
  localparam int TOP_OFF_MSB = 15;
  localparam int TOP_OFF_LSB = 13;
  localparam int BOT_OFF_MSB = 12;
  localparam int BOT_OFF_LSB = 9;
  localparam int OUT_SHIFT   = 8;
  localparam int PROD_W      = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_IMP,
    ST_WAIT_SAMP,
    ST_DRAIN
  } state_t;
endpackage

// File: rtl/reverb_tap_mac_tap_multiplier.sv
// Registered signed-sample x unsigned-weight multiply with optional negate.
// The result appears one cycle after in_vld.
module tap_multiplier
  import reverb_tap_mac_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic signed [15:0]       sample,
  input  logic [MULT_MSB:0]        mult,
  input  logic                     neg,
  output logic                     out_vld,
  output logic signed [PROD_W-1:0] prod
);
  logic signed [PROD_W-1:0] s_ext, m_ext, raw;

  assign s_ext = {{(PROD_W-16){sample[15]}}, sample};
  assign m_ext = {{(PROD_W-MULT_MSB-1){1'b0}}, mult};
  assign raw   = s_ext * m_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      prod    <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) prod <= neg ? -raw : raw;
    end
  end
endmodule

// File: rtl/reverb_tap_mac.sv
// Convolution MAC: pairs impulse words with delayed samples, accumulates saturating
// weighted taps, and emits one saturated 16-bit reverb sample per frame.
module reverb_tap_mac
  import reverb_tap_mac_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int TAP_BITS  = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic [TAP_BITS-1:0] tap_count,
  input  logic                word_valid,
  input  logic                word_is_impulse,
  input  logic [15:0]         word_data,
  output logic [15:0]         sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                seq_err,
  output logic                overrun
);
  state_t                     state;
  logic [TAP_BITS-1:0]        tc_lat, tap_cnt;
  logic                       neg_lat, flush;
  logic [MULT_MSB:0]          mult_lat;
  logic                       prod_vld;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] acc, acc_sum, shifted;
  logic signed [ACC_WIDTH:0]  acc_ext, prod_ext, wide;
  logic                       imp_ok, samp_ok, last_tap, drain_emit, emit, out_fits;
  logic [15:0]                out_sat;

  assign imp_ok     = word_valid &&  word_is_impulse && state == ST_WAIT_IMP;
  assign samp_ok    = word_valid && !word_is_impulse && state == ST_WAIT_SAMP;
  assign last_tap   = (tap_cnt + 1'b1) == tc_lat;
  // flush carries the tail of a frame cut short by frame_start; it outranks DRAIN
  assign drain_emit = state == ST_DRAIN && !prod_vld && !flush;
  assign emit       = flush || drain_emit;

  tap_multiplier u_mul (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (samp_ok),
    .sample  (word_data),
    .mult    (mult_lat),
    .neg     (neg_lat),
    .out_vld (prod_vld),
    .prod    (prod)
  );

  assign acc_ext  = {acc[ACC_WIDTH-1], acc};
  assign prod_ext = prod_vld ? {{(ACC_WIDTH+1-PROD_W){prod[PROD_W-1]}}, prod} : '0;
  assign wide     = acc_ext + prod_ext;
  assign acc_sum  = (wide[ACC_WIDTH] == wide[ACC_WIDTH-1]) ? wide[ACC_WIDTH-1:0] :
                    wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                      {1'b0, {(ACC_WIDTH-1){1'b1}}};

  assign shifted  = acc_sum >>> OUT_SHIFT;
  assign out_fits = (shifted[ACC_WIDTH-1:15] == '0) || (&shifted[ACC_WIDTH-1:15]);
  assign out_sat  = out_fits ? shifted[15:0] : (shifted[ACC_WIDTH-1] ? 16'h8000 : 16'h7FFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      tc_lat       <= '0;
      tap_cnt      <= '0;
      neg_lat      <= 1'b0;
      mult_lat     <= '0;
      acc          <= '0;
      flush        <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      seq_err      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= emit;
      if (emit) sample_out <= out_sat;
      seq_err <= word_valid && ((state == ST_WAIT_IMP  && !word_is_impulse) ||
                                (state == ST_WAIT_SAMP &&  word_is_impulse));
      overrun <= frame_start && state != ST_IDLE;
      busy    <= frame_start || flush || state != ST_IDLE;
      flush   <= frame_start && state != ST_IDLE && !drain_emit;
      // an overrun keeps accumulating so the old frame's in-flight product lands before the flush
      if (emit || (frame_start && state == ST_IDLE)) acc <= '0;
      else                                           acc <= acc_sum;
      if (imp_ok) begin
        neg_lat  <= word_data[NEG_BIT];
        mult_lat <= word_data[MULT_MSB:0];
      end
      case (state)
        ST_WAIT_IMP:  if (imp_ok) state <= ST_WAIT_SAMP;
        ST_WAIT_SAMP: if (samp_ok) begin
          tap_cnt <= tap_cnt + 1'b1;
          state   <= last_tap ? ST_DRAIN : ST_WAIT_IMP;
        end
        ST_DRAIN:     if (drain_emit) state <= ST_IDLE;
        default: ;
      endcase
      if (frame_start) begin
        tc_lat  <= tap_count;
        tap_cnt <= '0;
        state   <= (tap_count == '0) ? ST_DRAIN : ST_WAIT_IMP;
      end
    end
  end
endmodule
